// File: rtl/trigger_event_buffer.sv
// Trigger ID FIFO between the trigger stage and SPI readout, with a registered pop path and a saturating drop counter.
// Optional TRIGGER_TIMESTAMP_EN: each entry also carries a free-running TS_W timestamp in its MSBs.
module trigger_event_buffer #(
  parameter int ID_W   = 16,
  parameter int ADDR_W = 4,
  parameter int TS_W   = 24,
  parameter int OVF_W  = 8,
`ifdef TRIGGER_TIMESTAMP_EN
  localparam int RD_W  = TS_W + ID_W
`else
  localparam int RD_W  = ID_W
`endif
) (
  input  logic              sampling_clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              wr_valid,
  input  logic [ID_W-1:0]   wr_id,
  input  logic              rd_req,
  output logic [RD_W-1:0]   rd_data,
  output logic              rd_valid,
  output logic [ADDR_W:0]   level,
  output logic [OVF_W-1:0]  overflow_count,
  output logic              interrupt
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_PRESENT} rd_state_e;

  rd_state_e         state_q, state_d;
  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic [OVF_W-1:0]  ovf_q, ovf_d;
  logic [RD_W-1:0]   rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              int_q, int_d;
  logic [RD_W-1:0]   ram_q;
  logic [RD_W-1:0]   wr_entry;
  logic              full, empty, rd_take, do_pop, do_push;

  logic [RD_W-1:0]   mem [2**ADDR_W];

`ifdef TRIGGER_TIMESTAMP_EN
  logic [TS_W-1:0]   ts_q, ts_d;

  // Free-running stamp; deliberately untouched by clear.
  always_comb ts_d = ts_q + 1'b1;

  always_ff @(posedge sampling_clk or negedge reset) begin
    if (!reset) ts_q <= '0;
    else        ts_q <= ts_d;
  end

  assign wr_entry = {ts_q, wr_id};
`else
  assign wr_entry = wr_id;
`endif

  assign full    = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                   (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign rd_take = rd_req && !clear && (state_q != S_FETCH);
  assign do_pop  = rd_take && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the write.
  assign do_push = wr_valid && !clear && (!full || do_pop);

  // NOTE: storage has no reset; rd_valid and level gate every read, so stale contents are never observed.
  always_ff @(posedge sampling_clk) begin
    if (do_push) mem[wr_ptr_q[ADDR_W-1:0]] <= wr_entry;
    if (do_pop)  ram_q <= mem[rd_ptr_q[ADDR_W-1:0]];
  end

  // NOTE: every _d gets its hold value first, so no path through this block can infer a latch.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    ovf_d      = ovf_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_valid_q;

    if (clear) begin
      state_d    = S_IDLE;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      ovf_d      = '0;
      rd_data_d  = '0;
      rd_valid_d = 1'b0;
    end else begin
      if (do_push)                       wr_ptr_d = wr_ptr_q + 1'b1;
      else if (wr_valid && ovf_q != '1)  ovf_d    = ovf_q + 1'b1;
      if (do_pop)                        rd_ptr_d = rd_ptr_q + 1'b1;

      unique case ({do_push, do_pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase

      unique case (state_q)
        S_FETCH: begin
          rd_data_d  = ram_q;
          rd_valid_d = 1'b1;
          state_d    = S_PRESENT;
        end
        default: begin
          if (rd_take) begin
            rd_valid_d = 1'b0;
            if (!empty) begin
              state_d = S_FETCH;
            end else begin
              rd_data_d = '0;
              state_d   = S_IDLE;
            end
          end
        end
      endcase
    end

    int_d = (level_d == '0);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge sampling_clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      ovf_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      int_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      ovf_q      <= ovf_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      int_q      <= int_d;
    end
  end

  assign rd_data        = rd_data_q;
  assign rd_valid       = rd_valid_q;
  assign level          = level_q;
  assign overflow_count = ovf_q;
  assign interrupt      = int_q;

endmodule

// File: tb/tb_trigger_event_buffer.sv
// Randomised and directed bench for trigger_event_buffer against a queue-based reference model.
// Also exercises the TRIGGER_TIMESTAMP_EN build when that macro is defined.
module tb_trigger_event_buffer;

  localparam int ID_W   = 16;
  localparam int ADDR_W = 4;
  localparam int TS_W   = 8;
  localparam int OVF_W  = 8;
  localparam int DEPTH  = 2**ADDR_W;
`ifdef TRIGGER_TIMESTAMP_EN
  localparam int RD_W   = TS_W + ID_W;
`else
  localparam int RD_W   = ID_W;
`endif

  logic              sampling_clk = 1'b0;
  logic              reset = 1'b0;
  logic              clear = 1'b0;
  logic              wr_valid = 1'b0;
  logic [ID_W-1:0]   wr_id = '0;
  logic              rd_req = 1'b0;
  logic [RD_W-1:0]   rd_data;
  logic              rd_valid;
  logic [ADDR_W:0]   level;
  logic [OVF_W-1:0]  overflow_count;
  logic              interrupt;

  trigger_event_buffer #(
    .ID_W(ID_W), .ADDR_W(ADDR_W), .TS_W(TS_W), .OVF_W(OVF_W)
  ) dut (
    .sampling_clk   (sampling_clk),
    .reset          (reset),
    .clear          (clear),
    .wr_valid       (wr_valid),
    .wr_id          (wr_id),
    .rd_req         (rd_req),
    .rd_data        (rd_data),
    .rd_valid       (rd_valid),
    .level          (level),
    .overflow_count (overflow_count),
    .interrupt      (interrupt)
  );

  always #5 sampling_clk = ~sampling_clk;

  // Reference model: queue of stored entries plus the visible read-port state.
  logic [RD_W-1:0] q_m[$];
  int              ovf_m;
  bit              pend_m;
  logic [RD_W-1:0] fetch_m;
  logic [RD_W-1:0] data_m;
  bit              valid_m;
  logic [TS_W-1:0] ts_m;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    q_m.delete();
    ovf_m = 0; pend_m = 0; fetch_m = '0; data_m = '0; valid_m = 0; ts_m = '0;
  endtask

  task automatic model_edge(input bit c, input bit wv, input logic [ID_W-1:0] id, input bit rq);
    logic [RD_W-1:0] ent;
    if (!reset) begin
      model_reset();
      return;
    end
`ifdef TRIGGER_TIMESTAMP_EN
    ent = {ts_m, id};
`else
    ent = id;
`endif
    ts_m = ts_m + 1'b1;
    if (c) begin
      q_m.delete();
      ovf_m = 0; pend_m = 0; data_m = '0; valid_m = 0;
      return;
    end
    if (pend_m) begin
      data_m = fetch_m; valid_m = 1; pend_m = 0;
    end else if (rq) begin
      valid_m = 0;
      if (q_m.size() > 0) begin
        fetch_m = q_m.pop_front();
        pend_m  = 1;
      end else begin
        data_m = '0;
      end
    end
    if (wv) begin
      if (q_m.size() < DEPTH) q_m.push_back(ent);
      else if (ovf_m < 2**OVF_W - 1) ovf_m++;
    end
  endtask

  task automatic compare_all();
    check("rd_valid", rd_valid, valid_m);
    check("rd_data", rd_data, data_m);
    check("level", level, q_m.size());
    check("overflow_count", overflow_count, ovf_m);
    check("interrupt", interrupt, q_m.size() == 0);
  endtask

  task automatic cycle(input bit c, input bit wv, input logic [ID_W-1:0] id, input bit rq);
    clear = c; wr_valid = wv; wr_id = id; rd_req = rq;
    @(posedge sampling_clk);
    model_edge(c, wv, id, rq);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, '0, 0);
  endtask

  task automatic push(input logic [ID_W-1:0] id);
    cycle(0, 1, id, 0);
  endtask

  // Issues one read and returns the low ID bits two edges later.
  task automatic pop(output logic [ID_W-1:0] id, output logic v);
    cycle(0, 0, '0, 1);
    idle(1);
    id = rd_data[ID_W-1:0];
    v  = rd_valid;
  endtask

  logic [ID_W-1:0] got_id;
  logic            got_v;
  int              wv_pct;

  initial begin
    model_reset();
    #12;
    check("reset_level", level, 0);
    check("reset_int", interrupt, 1);
    check("reset_valid", rd_valid, 0);
    check("reset_data", rd_data, 0);
    check("reset_ovf", overflow_count, 0);
    reset = 1'b1;
    @(negedge sampling_clk);

    // Three pushes, reads four cycles apart.
    push(16'h0001);
    check("int_after_push", interrupt, 0);
    push(16'h0002); push(16'h0003);
    check("level3", level, 3);
    for (int i = 1; i <= 3; i++) begin
      pop(got_id, got_v);
      check("seq_id", got_id, i);
      check("seq_valid", got_v, 1);
      idle(2);
    end
    check("level0", level, 0);
    check("int_released", interrupt, 1);

    // Overfill by two, then drain in order.
    for (int i = 0; i < 18; i++) push(16'h0100 + i[15:0]);
    check("full_level", level, 16);
    check("full_ovf", overflow_count, 2);
    for (int i = 0; i < 16; i++) begin
      pop(got_id, got_v);
      check("drain_id", got_id, 16'h0100 + i[15:0]);
    end

    // Full with simultaneous write and pop.
    cycle(1, 0, '0, 0);
    for (int i = 0; i < 16; i++) push(16'h0200 + i[15:0]);
    cycle(0, 1, 16'hBEEF, 1);
    check("fullrw_ovf", overflow_count, 0);
    check("fullrw_level", level, 16);
    idle(1);
    check("fullrw_first", rd_data[ID_W-1:0], 16'h0200);
    for (int i = 1; i <= 16; i++) begin
      pop(got_id, got_v);
      check("fullrw_id", got_id, (i == 16) ? 16'hBEEF : 16'h0200 + i[15:0]);
    end

    // Read on empty, then write and read together on empty.
    pop(got_id, got_v);
    check("empty_valid", got_v, 0);
    check("empty_data", rd_data, 0);
    cycle(0, 1, 16'h0777, 1);
    idle(1);
    check("empty_rw_level", level, 1);
    check("empty_rw_valid", rd_valid, 0);
    pop(got_id, got_v);
    check("empty_rw_entry", got_id, 16'h0777);

    // Clear beats a same-cycle write.
    for (int i = 0; i < 19; i++) push(16'h0300 + i[15:0]);
    for (int i = 0; i < 11; i++) pop(got_id, got_v);
    check("pre_clear_level", level, 5);
    check("pre_clear_ovf", overflow_count, 3);
    cycle(1, 1, 16'h0999, 0);
    check("clear_level", level, 0);
    check("clear_ovf", overflow_count, 0);
    check("clear_int", interrupt, 1);
    check("clear_valid", rd_valid, 0);

    // Overflow counter saturates.
    for (int i = 0; i < DEPTH + 300; i++) push(i[15:0]);
    check("ovf_sat", overflow_count, 8'hFF);
    cycle(1, 0, '0, 0);

    // Reset while a fetch is in flight.
    push(16'h0ABC); push(16'h0ABD);
    cycle(0, 0, '0, 1);
    #2 reset = 1'b0;
    #1;
    model_reset();
    check("rst_fetch_valid", rd_valid, 0);
    check("rst_fetch_level", level, 0);
    check("rst_fetch_int", interrupt, 1);
    @(negedge sampling_clk);
    reset = 1'b1;
    idle(2);

`ifdef TRIGGER_TIMESTAMP_EN
    begin
      int guard = 0;
      while (ts_m != 8'hFE && guard < 600) begin idle(1); guard++; end
      check("ts_reach_fe", ts_m, 8'hFE);
      push(16'hA0A0);
      guard = 0;
      while (ts_m != 8'h01 && guard < 600) begin idle(1); guard++; end
      check("ts_reach_01", ts_m, 8'h01);
      push(16'hA0A1);
      cycle(0, 0, '0, 1); idle(1);
      check("ts_entry0", rd_data, {8'hFE, 16'hA0A0});
      cycle(0, 0, '0, 1); idle(1);
      check("ts_entry1", rd_data, {8'h01, 16'hA0A1});
    end
`endif

    // Randomised traffic in phases of differing write pressure.
    for (int p = 0; p < 4; p++) begin
      wv_pct = (p == 0) ? 80 : (p == 1) ? 30 : (p == 2) ? 50 : 95;
      for (int i = 0; i < 600; i++) begin
        cycle($urandom_range(0, 63) == 0,
              $urandom_range(0, 99) < wv_pct,
              ID_W'($urandom),
              $urandom_range(0, 2) == 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/trigger_event_buffer.md
Name: trigger_event_buffer

Overview:
- Buffers trigger IDs, and optionally timestamps, between the trigger stage and the SPI readout.
- Each trigger decoded by the trigger block is pushed into a small FIFO on sampling_clk.
- The SPI block pops one entry per transaction, and the MCU interrupt stays asserted while entries remain.
- Triggers closer together than the MCU's readout time are no longer lost.

Parameters:
- ID_W, 16, width of the trigger ID word
- ADDR_W, 4, FIFO address width; depth = 2**ADDR_W = 16 entries
- TS_W, 24, timestamp width; used only with TRIGGER_TIMESTAMP_EN
- OVF_W, 8, width of the saturating overflow counter

Ports:
- sampling_clk  in  1  PLL clock; the only clock in the block
- reset  in  1  asynchronous, active-low reset
- clear  in  1  synchronous flush, active high, one-cycle pulse
- wr_valid  in  1  one-cycle pulse: a new trigger ID is valid on wr_id
- wr_id  in  ID_W  trigger ID from the trigger block
- rd_req  in  1  one-cycle pulse from SPI at transaction start (synchronised CS fall)
- rd_data  out  RD_W  popped entry
  - RD_W = TS_W+ID_W when the macro is defined, else ID_W
  - timestamp occupies the MSBs
- rd_valid  out  1  high while rd_data holds a successfully popped entry
- level  out  ADDR_W+1  current occupancy, 0 to 2**ADDR_W
- overflow_count  out  OVF_W  number of dropped triggers, saturating
- interrupt  out  1  active low; low while level != 0

Behaviour:
- Reset (async, reset=0):
  - pointers = 0, level = 0, rd_data = 0, rd_valid = 0
  - overflow_count = 0, interrupt = 1, timestamp = 0, read FSM = IDLE
- Storage: dual-pointer RAM, 2**ADDR_W x RD_W, synchronous read. Pointers are ADDR_W+1 bits (extra wrap bit).
  - full when the pointers differ only in the MSB
  - empty when the pointers are equal
- Write, in the same cycle as wr_valid:
  - if not full: store the entry, wr_ptr++, wrapping naturally modulo 2**(ADDR_W+1)
  - if full: drop the entry, overflow_count++, saturating at 2**OVF_W-1
- Read FSM: IDLE -> FETCH -> PRESENT.
  - IDLE or PRESENT, rd_req=1, not empty:
    - rd_ptr++ that cycle; RAM address = old rd_ptr
    - rd_valid drops to 0; go to FETCH
  - IDLE or PRESENT, rd_req=1, empty: rd_valid <= 0, rd_data <= 0; go to IDLE
  - FETCH: rd_data <= RAM output, rd_valid <= 1; go to PRESENT
  - Latency: rd_req in cycle N gives rd_data/rd_valid valid in cycle N+2.
  - rd_data holds stable until the next rd_req or clear.
  - rd_req arriving while in FETCH is ignored: no pop, no state change.
- level is registered.
  - wr accepted and no pop: +1; pop and no wr accepted: -1
  - both in the same cycle: unchanged
- Full plus simultaneous wr_valid and pop: the pop frees a slot, so the write is accepted and overflow_count is unchanged.
- Empty plus simultaneous wr_valid and rd_req: the write is stored and the read sees empty, so rd_valid = 0.
  - The entry remains; level = 1.
- interrupt is registered: next cycle = (next level == 0). It deasserts the cycle after the last entry is popped.
- clear has priority over wr_valid and rd_req in the same cycle:
  - pointers, level and overflow_count go to 0
  - rd_valid = 0, rd_data = 0, FSM = IDLE, interrupt = 1
  - the timestamp is not cleared
- Reset asserted mid-FETCH: all state returns to reset values immediately; no partial entry appears.

Optional Feature:
- Macro: TRIGGER_TIMESTAMP_EN.
- Defined:
  - a free-running TS_W counter increments every sampling_clk and wraps from 2**TS_W-1 to 0
  - each accepted write stores {counter value in the wr_valid cycle, wr_id}
  - RD_W = TS_W+ID_W
- Not defined: no counter is instantiated, entries hold wr_id only, RD_W = ID_W.

Test Plan:
- Reset, then push IDs 0x0001, 0x0002, 0x0003 and pulse rd_req three times, 4 cycles apart.
  - Each read gives rd_data = 0x0001, 0x0002, 0x0003 at N+2 with rd_valid=1.
  - level goes 3 -> 0; interrupt goes low after the first push and high after the third pop.
- Push 18 IDs with no reads (ADDR_W=4) -> level=16, overflow_count=2; the first 16 IDs read back in order.
- With the buffer full, assert wr_valid (0xBEEF) and rd_req in the same cycle.
  - overflow_count unchanged, level stays 16
  - 0xBEEF is read back as the 16th subsequent pop
- With the buffer empty, pulse rd_req -> rd_valid=0 and rd_data=0 at N+2, FSM back in IDLE.
  - wr_valid plus rd_req together on empty -> level=1, rd_valid=0.
- With 5 entries and overflow_count=3, pulse clear together with wr_valid.
  - Next cycle: level=0, overflow_count=0, interrupt=1, the write is discarded.
  - Separately, asserting reset during FETCH -> rd_valid=0 and level=0 at once.
- TRIGGER_TIMESTAMP_EN with TS_W=8: push at counter values 0xFE and then 0x01 (after wrap).
  - Reads give {0xFE, id0} and then {0x01, id1}.
